// File: rtl/squeeze_stream_ctrl.sv
// Squeeze-phase controller for the Keccak core: captures each squeeze window into an
// AXI-Stream beat, trims the final beat to the requested length and requests permutations.
module squeeze_stream_ctrl #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned LEN_W  = 32,
  localparam int unsigned KEEP_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  out_len_i,
  input  logic              stop_i,
  input  logic [DATA_W-1:0] sq_data_i,
  input  logic [KEEP_W-1:0] sq_keep_i,
  input  logic              sq_last_i,
  input  logic              sq_perm_needed_i,
  input  logic [CNT_W-1:0]  sq_bytes_next_i,
  output logic [CNT_W-1:0]  sq_bytes_o,
  output logic              perm_req_o,
  input  logic              perm_done_i,
  output logic [DATA_W-1:0] m_axis_tdata_o,
  output logic [KEEP_W-1:0] m_axis_tkeep_o,
  output logic              m_axis_tvalid_o,
  output logic              m_axis_tlast_o,
  input  logic              m_axis_tready_i,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {StIdle, StCapture, StSend, StPerm, StDone} state_e;

  state_e            state_q;
  logic [LEN_W-1:0]  remaining_q;
  logic              unlimited_q;
  logic              stop_pend_q;
  logic              perm_pend_q;

  logic [KEEP_W-1:0] cap_keep;
  logic [CNT_W-1:0]  cap_cnt;
  logic [CNT_W-1:0]  tx_cnt;
  logic [LEN_W-1:0]  rem_after;

  function automatic logic [CNT_W-1:0] popcnt(input logic [KEEP_W-1:0] k);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < KEEP_W; i++) begin
      c = c + CNT_W'(k[i]);
    end
    return c;
  endfunction

  always_comb begin
    cap_keep = sq_keep_i;
    // Only the final, short beat of a fixed-length digest is trimmed.
    if (!unlimited_q && (remaining_q < LEN_W'(KEEP_W))) begin
      for (int unsigned i = 0; i < KEEP_W; i++) begin
        if (LEN_W'(i) >= remaining_q) cap_keep[i] = 1'b0;
      end
    end
    cap_cnt   = popcnt(cap_keep);
    tx_cnt    = popcnt(m_axis_tkeep_o);
    rem_after = (remaining_q > LEN_W'(tx_cnt)) ? remaining_q - LEN_W'(tx_cnt) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      remaining_q     <= '0;
      unlimited_q     <= 1'b0;
      stop_pend_q     <= 1'b0;
      perm_pend_q     <= 1'b0;
      sq_bytes_o      <= '0;
      perm_req_o      <= 1'b0;
      m_axis_tdata_o  <= '0;
      m_axis_tkeep_o  <= '0;
      m_axis_tvalid_o <= 1'b0;
      m_axis_tlast_o  <= 1'b0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (stop_i && (state_q inside {StCapture, StSend, StPerm})) begin
        stop_pend_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            remaining_q <= out_len_i;
            unlimited_q <= (out_len_i == '0);
            sq_bytes_o  <= '0;
            stop_pend_q <= 1'b0;
            busy_o      <= 1'b1;
            state_q     <= StCapture;
          end
        end
        StCapture: begin
          m_axis_tdata_o  <= sq_data_i;
          m_axis_tkeep_o  <= cap_keep;
          m_axis_tlast_o  <= sq_last_i | (!unlimited_q && (remaining_q <= LEN_W'(cap_cnt)))
                             | stop_pend_q;
          perm_pend_q     <= sq_perm_needed_i;
          m_axis_tvalid_o <= 1'b1;
          state_q         <= StSend;
        end
        StSend: begin
          if (m_axis_tready_i) begin
            remaining_q     <= rem_after;
            m_axis_tvalid_o <= 1'b0;
            if (m_axis_tlast_o) begin
              done_o  <= 1'b1;
              state_q <= StDone;
            end else if (perm_pend_q) begin
              sq_bytes_o <= '0;
              perm_req_o <= 1'b1;
              state_q    <= StPerm;
            end else begin
              sq_bytes_o <= sq_bytes_next_i;
              state_q    <= StCapture;
            end
          end
        end
        StPerm: begin
          if (perm_done_i) begin
            perm_req_o <= 1'b0;
            if (stop_pend_q) begin
              done_o  <= 1'b1;
              state_q <= StDone;
            end else begin
              state_q <= StCapture;
            end
          end
        end
        StDone: begin
          busy_o  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_squeeze_stream_ctrl.sv
// Randomized bench for squeeze_stream_ctrl: a mock squeeze window feeds the DUT and a
// byte-level reference model predicts every beat, permutation count and completion.
module tb_squeeze_stream_ctrl;
  localparam int unsigned DATA_W = 256;
  localparam int unsigned KEEP_W = 32;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned LEN_W  = 32;
  localparam int unsigned NoWin  = 32'hFFFF;

  logic              clk, rst_n, start, stop, perm_done, tready;
  logic [LEN_W-1:0]  out_len;
  logic [DATA_W-1:0] sq_data, tdata;
  logic [KEEP_W-1:0] sq_keep, tkeep;
  logic              sq_last, sq_perm_needed, perm_req, tvalid, tlast, busy, done;
  logic [CNT_W-1:0]  sq_bytes_next, sq_bytes;

  squeeze_stream_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .out_len_i(out_len), .stop_i(stop),
    .sq_data_i(sq_data), .sq_keep_i(sq_keep), .sq_last_i(sq_last),
    .sq_perm_needed_i(sq_perm_needed), .sq_bytes_next_i(sq_bytes_next),
    .sq_bytes_o(sq_bytes), .perm_req_o(perm_req), .perm_done_i(perm_done),
    .m_axis_tdata_o(tdata), .m_axis_tkeep_o(tkeep), .m_axis_tvalid_o(tvalid),
    .m_axis_tlast_o(tlast), .m_axis_tready_i(tready), .busy_o(busy), .done_o(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic [CNT_W-1:0]  sqb;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       mon_b;
  int unsigned n_checks = 0, n_fail = 0;
  int unsigned cyc = 0, start_cyc = 0, acc = 0, done_cnt = 0, perm_cnt = 0;
  int unsigned seed = 0, perm_idx = 0, win_cnt = 0, rate = 136, last_win = NoWin;
  int unsigned stop_mode = 0, stop_beat = 0, ready_pct = 100, stall_left = 0, spur_pct = 0;
  int          stall_beat = -1;
  bit          stop_sent = 1'b1, first_seen = 1'b1;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] win_data(int unsigned s, int unsigned p, int unsigned b);
    logic [DATA_W-1:0] d;
    for (int unsigned k = 0; k < 8; k++) begin
      d[k*32 +: 32] = s ^ (p * 32'h9E3779B9) ^ (b << 8) ^ (k * 32'h01000193) ^ 32'h5A5A0000;
    end
    return d;
  endfunction

  function automatic int unsigned win_bytes(int unsigned r, int unsigned b);
    if (b >= r || r - b >= 32) return 32;
    return r - b;
  endfunction

  function automatic logic [KEEP_W-1:0] low_mask(int unsigned n);
    logic [63:0] m;
    m = (64'd1 << n) - 64'd1;
    return m[KEEP_W-1:0];
  endfunction

  // Mock squeeze window logic: a rate-sized block read out 32 bytes at a time.
  always_comb begin
    sq_data        = win_data(seed, perm_idx, 32'(sq_bytes));
    sq_keep        = low_mask(win_bytes(rate, 32'(sq_bytes)));
    sq_perm_needed = (32'(sq_bytes) + 32 >= rate);
    sq_last        = (win_cnt == last_win);
    sq_bytes_next  = sq_bytes + 8'd32;
  end

  // Reference: walk the output byte stream window by window.
  task automatic build_model(input int unsigned len, input int unsigned r, input int unsigned lw,
                             input int unsigned smode, input int unsigned sbeat,
                             output int unsigned perms);
    int unsigned sqb, p, rem, n, cnt, w;
    bit unl, force_last, drain, stopped;
    beat_t b;
    sqb = 0; p = 0; rem = len; unl = (len == 0); w = 0; force_last = 0; perms = 0;
    exp_q.delete();
    for (int g = 0; g < 64; g++) begin
      n   = win_bytes(r, sqb);
      cnt = (!unl && rem < n) ? rem : n;
      b.data = win_data(seed, p, sqb);
      b.keep = low_mask(cnt);
      b.sqb  = CNT_W'(sqb);
      b.last = (w == lw) || (!unl && rem <= cnt) || force_last;
      exp_q.push_back(b);
      rem = (rem > cnt) ? rem - cnt : 0;
      if (b.last) break;
      drain   = (sqb + 32 >= r);
      stopped = (smode == 1 && w == sbeat) || (smode == 2 && drain && perms == 0);
      if (drain) begin
        perms++; p++; sqb = 0;
        if (stopped) break;
      end else begin
        sqb += 32;
      end
      if (stopped) force_last = 1;
      w++;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_beat >= 0 && tvalid && acc == stall_beat && stall_left > 0) begin
        tready = 1'b0;
        stall_left--;
      end else begin
        tready = ($urandom_range(99) < ready_pct);
      end
    end
  end

  initial begin
    stop = 1'b0;
    forever begin
      @(posedge clk); #1;
      stop = 1'b0;
      if (!stop_sent && ((stop_mode == 1 && tvalid && acc == stop_beat) ||
                         (stop_mode == 2 && perm_req) || (stop_mode == 3 && !busy))) begin
        stop = 1'b1;
        stop_sent = 1'b1;
      end
    end
  end

  initial begin
    perm_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      perm_done = 1'b0;
      if (perm_req) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        perm_done = 1'b1;
        perm_idx++;
        @(posedge clk); #1;
        perm_done = 1'b0;
      end else if ($urandom_range(99) < spur_pct) begin
        perm_done = 1'b1;  // outside PERM this must be ignored
      end
    end
  end

  // Monitor: beat scoreboard, hold-stable checks, latency and done width.
  initial begin
    bit stall_prev, prev_done, prev_preq, prev_last;
    logic [DATA_W-1:0] prev_data;
    logic [KEEP_W-1:0] prev_keep;
    stall_prev = 0; prev_done = 0; prev_preq = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 0; prev_done = 0; prev_preq = 0;
      end else begin
        if (stall_prev) begin
          check_val("hold_valid", tvalid, 1'b1);
          check_val("hold_data", tdata, prev_data);
          check_val("hold_keep", tkeep, prev_keep);
          check_val("hold_last", tlast, prev_last);
        end
        if (tvalid && !first_seen) begin
          first_seen = 1;
          check_val("first_latency", cyc - start_cyc, 2);
        end
        if (tvalid && tready) begin
          if (exp_q.size() == 0) begin
            check_val("extra_beat", exp_q.size(), 1);
          end else begin
            mon_b = exp_q.pop_front();
            check_val("beat_data", tdata, mon_b.data);
            check_val("beat_keep", tkeep, mon_b.keep);
            check_val("beat_last", tlast, mon_b.last);
            check_val("beat_sq_bytes", sq_bytes, mon_b.sqb);
          end
          acc++;
          win_cnt++;
        end
        if (prev_done) begin
          check_val("done_width", done, 1'b0);
          check_val("busy_after_done", busy, 1'b0);
        end
        if (done) done_cnt++;
        if (perm_req && !prev_preq) perm_cnt++;
        stall_prev = tvalid && !tready;
        prev_data = tdata; prev_keep = tkeep; prev_last = tlast;
        prev_done = done; prev_preq = perm_req;
      end
    end
  end

  task automatic start_run(input int unsigned len, input int unsigned r, input int unsigned lw,
                           input int unsigned smode, input int unsigned sbeat,
                           input int unsigned rpct, input int stall_b, output int unsigned perms);
    seed = $urandom; rate = r; last_win = lw; perm_idx = 0; win_cnt = 0; acc = 0;
    perm_cnt = 0; stop_mode = smode; stop_beat = sbeat; stop_sent = (smode == 0);
    ready_pct = rpct; stall_beat = stall_b; stall_left = 5;
    build_model(len, r, lw, smode, sbeat, perms);
    @(posedge clk); #1;
    start = 1'b1; out_len = len; start_cyc = cyc; first_seen = 0;
    @(posedge clk); #1;
    start = 1'b0; out_len = $urandom;
  endtask

  task automatic run_case(input int unsigned len, input int unsigned r, input int unsigned lw,
                          input int unsigned smode, input int unsigned sbeat,
                          input int unsigned rpct, input int stall_b);
    int unsigned perms, d0;
    d0 = done_cnt;
    start_run(len, r, lw, smode, sbeat, rpct, stall_b, perms);
    for (int i = 0; i < 4000 && done_cnt == d0; i++) begin
      @(negedge clk); #1;
    end
    check_val("done_seen", done_cnt - d0, 1);
    repeat (2) @(negedge clk);
    #1;
    check_val("beats_left", exp_q.size(), 0);
    check_val("perm_count", perm_cnt, perms);
    check_val("idle_busy", busy, 1'b0);
  endtask

  initial begin
    int unsigned perms, rl[5], r, sm;
    rl[0] = 136; rl[1] = 72; rl[2] = 168; rl[3] = 104; rl[4] = 144;
    rst_n = 1'b0; start = 1'b0; out_len = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_tvalid", tvalid, 1'b0);
    check_val("rst_tdata", tdata, 0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_sq_bytes", sq_bytes, 0);
    rst_n = 1'b1;

    run_case(32, 136, 0, 0, 0, 100, -1);         // SHA3-256
    run_case(64, 72, 1, 0, 0, 100, -1);          // SHA3-512
    run_case(200, 168, NoWin, 0, 0, 100, -1);    // SHAKE128, trimmed across a permutation
    run_case(64, 72, 1, 0, 0, 100, 1);           // backpressure on beat 2
    run_case(0, 168, NoWin, 1, 2, 100, -1);      // XOF stopped during beat 3
    run_case(0, 72, NoWin, 2, 0, 70, -1);        // XOF stopped during PERM

    stop_mode = 3; stop_sent = 0;                // stop while idle is ignored
    repeat (4) @(posedge clk);
    run_case(100, 136, NoWin, 0, 0, 100, -1);

    // Reset mid-beat, then a fresh run.
    start_run(64, 72, 1, 0, 0, 0, -1, perms);
    for (int i = 0; i < 20 && !tvalid; i++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("abort_tvalid", tvalid, 1'b0);
    check_val("abort_tlast", tlast, 1'b0);
    check_val("abort_tkeep", tkeep, 0);
    check_val("abort_tdata", tdata, 0);
    check_val("abort_busy", busy, 1'b0);
    check_val("abort_perm_req", perm_req, 1'b0);
    check_val("abort_sq_bytes", sq_bytes, 0);
    exp_q.delete();
    first_seen = 1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    run_case(64, 72, 1, 0, 0, 100, -1);

    spur_pct = 10;
    for (int t = 0; t < 24; t++) begin
      r  = rl[$urandom_range(4)];
      sm = $urandom_range(2);
      if (sm == 0)
        run_case($urandom_range(1, 400), r, ($urandom_range(1) != 0) ? NoWin : $urandom_range(8),
                 0, 0, $urandom_range(30, 100), -1);
      else if (sm == 1)
        run_case(($urandom_range(1) != 0) ? 0 : $urandom_range(1, 400), r, NoWin, 1,
                 $urandom_range(6), $urandom_range(30, 100), -1);
      else
        run_case(0, r, NoWin, 2, 0, $urandom_range(30, 100), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
